// File: rtl/ig_pkg.sv
// Shared types and constants for the gradient-to-image reconstruction block.
package ig_pkg;
  localparam int WIDTH_DEF  = 256;
  localparam int HEIGHT_DEF = 256;
  localparam int AW_DEF     = 16;

  localparam int GX_MSB = 19;
  localparam int GX_LSB = 10;
  localparam int GY_MSB = 9;
  localparam int GY_LSB = 0;

  typedef logic [7:0]        pixel_t;
  typedef logic signed [9:0] grad_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } recon_state_t;

  // 11-bit two's complement sum of an unsigned pixel and a signed gradient.
  function automatic logic [10:0] pix_add(input pixel_t base, input grad_t g);
    return {3'b000, base} + {g[9], g};
  endfunction
endpackage

// File: rtl/ig_recon_line_buf.sv
// Previous-row pixel buffer: WIDTH x 8 registers, async read, sync write, no reset.
module line_buf
  import ig_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CW    = 8
) (
  input  logic          i_clk,
  input  logic [CW-1:0] i_rd_addr,
  output pixel_t        o_rd_data,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_addr,
  input  pixel_t        i_wr_data
);
  pixel_t r_mem [WIDTH];

  assign o_rd_data = r_mem[i_rd_addr];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end
endmodule

// File: rtl/ig_recon.sv
// Rebuilds an 8-bit image from packed {gx,gy} gradient words, one pixel per cycle.
// Build option IG_RECON_CLAMP_EN: saturate out-of-range pixels and count them.
module ig_recon
  import ig_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    seed,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   err_cnt,
  output logic          grad_rd,
  output logic [AW-1:0] grad_addr,
  input  logic [19:0]   grad_di,
  output logic          img_wr,
  output logic [AW-1:0] img_addr,
  output logic [7:0]    img_do,
  output logic [1:0]    dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] LAST_K = AW'(WIDTH * HEIGHT - 1);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  recon_state_t r_state;
  logic [AW-1:0] r_k;
  logic [CW-1:0] r_c;
  logic          r_row0;
  pixel_t        r_last;
  pixel_t        r_seed;

  logic          w_run, w_last, w_accept, w_next_row0;
  logic [CW-1:0] w_next_c;
  grad_t         w_gx, w_gy;
  pixel_t        w_above, w_calc, w_pix;

  assign w_run       = (r_state == RUN);
  assign w_accept    = (r_state != RUN) && start;
  assign w_last      = (r_k == LAST_K);
  assign w_next_c    = (r_c == LAST_C) ? '0 : r_c + CW'(1);
  assign w_next_row0 = r_row0 && (r_c != LAST_C);
  assign w_gx        = grad_di[GX_MSB:GX_LSB];
  assign w_gy        = grad_di[GY_MSB:GY_LSB];

`ifdef IG_RECON_CLAMP_EN
  logic [10:0] w_sum;
  logic        w_oor;
  assign w_sum  = r_row0 ? pix_add(r_last, w_gx) : pix_add(w_above, w_gy);
  assign w_oor  = |w_sum[10:8];
  assign w_calc = w_oor ? (w_sum[10] ? 8'h00 : 8'hFF) : w_sum[7:0];
`else
  assign w_calc = pixel_t'(r_row0 ? pix_add(r_last, w_gx) : pix_add(w_above, w_gy));
`endif

  // Pixel 0 has no gradient; it is the seed captured at start.
  assign w_pix = (r_k == '0) ? r_seed : w_calc;

  line_buf #(.WIDTH(WIDTH), .CW(CW)) u_lb (
    .i_clk     (clk),
    .i_rd_addr (r_c),
    .o_rd_data (w_above),
    .i_wr_en   (w_run),
    .i_wr_addr (r_c),
    .i_wr_data (w_pix)
  );

  // Read for pixel k+1: row 0 uses word k (gx), later rows word k+1-WIDTH (gy).
  assign grad_rd   = w_run && !w_last;
  assign grad_addr = !grad_rd ? '0 : (w_next_row0 ? r_k : r_k + AW'(1) - AW'(WIDTH));
  assign img_wr    = w_run;
  assign img_addr  = w_run ? r_k : '0;
  assign img_do    = w_run ? w_pix : '0;
  assign busy      = w_run;
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_c     <= '0;
      r_row0  <= 1'b1;
      r_last  <= '0;
      r_seed  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_k     <= '0;
            r_c     <= '0;
            r_row0  <= 1'b1;
            r_seed  <= seed;
          end
        end
        RUN: begin
          r_last <= w_pix;
          r_k    <= r_k + AW'(1);
          r_c    <= w_next_c;
          r_row0 <= w_next_row0;
          if (w_last) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IG_RECON_CLAMP_EN
  logic        r_err;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_run && (r_k != '0) && w_oor) begin
      r_err <= 1'b1;
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ig_recon.sv
// Self-checking bench for ig_recon: full-size flat frame plus 8x8 pattern, random and reset scenarios.
module tb_ig_recon;
  import ig_pkg::*;

  localparam int SW = 8;
  localparam int SN = 64;
  localparam int BN = 65536;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Small 8x8 instance
  logic        s_start = 1'b0;
  logic [7:0]  s_seed = '0;
  logic        s_busy, s_done, s_err, s_grad_rd, s_img_wr;
  logic [15:0] s_err_cnt;
  logic [7:0]  s_grad_addr, s_img_addr, s_img_do;
  logic [19:0] s_grad_di = '0;
  logic [1:0]  s_dbg;

  // Default-size instance
  logic        b_start = 1'b0;
  logic [7:0]  b_seed = '0;
  logic        b_busy, b_done, b_err, b_grad_rd, b_img_wr;
  logic [15:0] b_err_cnt;
  logic [15:0] b_grad_addr, b_img_addr;
  logic [7:0]  b_img_do;
  logic [19:0] b_grad_di = '0;
  logic [1:0]  b_dbg;

  ig_recon #(.WIDTH(SW), .HEIGHT(SW), .AW(8)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .seed(s_seed),
    .busy(s_busy), .done(s_done), .err(s_err), .err_cnt(s_err_cnt),
    .grad_rd(s_grad_rd), .grad_addr(s_grad_addr), .grad_di(s_grad_di),
    .img_wr(s_img_wr), .img_addr(s_img_addr), .img_do(s_img_do), .dbg_state(s_dbg)
  );

  ig_recon u_big (
    .clk(clk), .reset(reset), .start(b_start), .seed(b_seed),
    .busy(b_busy), .done(b_done), .err(b_err), .err_cnt(b_err_cnt),
    .grad_rd(b_grad_rd), .grad_addr(b_grad_addr), .grad_di(b_grad_di),
    .img_wr(b_img_wr), .img_addr(b_img_addr), .img_do(b_img_do), .dbg_state(b_dbg)
  );

  // Gradient memory model with one-cycle registered read
  logic [19:0] grad_mem [256];
  always @(posedge clk) begin
    if (s_grad_rd) s_grad_di <= grad_mem[s_grad_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         exp_errs;
  int         orig [SN];

  logic [7:0] cap_data [SN];
  logic [7:0] cap_addr [SN];
  int         cap_cyc  [SN];
  int         cap_n, done_cyc, rd_n;
  logic       busy0;

  // Reference: integrate gx along row 0, then add gy to the pixel above.
  task automatic build_expected(input int sd);
    int img [SN];
    int p;
    logic [19:0] w;
    logic signed [9:0] g;
    exp_q.delete();
    exp_errs = 0;
    for (int k = 0; k < SN; k++) begin
      if (k == 0) p = sd;
      else if (k < SW) begin w = grad_mem[k-1]; g = w[19:10]; p = img[k-1] + int'(g); end
      else begin w = grad_mem[k-SW]; g = w[9:0]; p = img[k-SW] + int'(g); end
      if (p < 0 || p > 255) begin
        exp_errs++;
`ifdef IG_RECON_CLAMP_EN
        p = (p < 0) ? 0 : 255;
`else
        p = p & 255;
`endif
      end
      img[k] = p;
      exp_q.push_back(8'(p));
    end
  endtask

  // Random image -> forward gradients; unused gradient fields get junk.
  task automatic make_random_image();
    logic [9:0] gx, gy;
    for (int k = 0; k < SN; k++) orig[k] = int'($urandom_range(0, 255));
    for (int j = 0; j < 256; j++) grad_mem[j] = 20'($urandom);
    for (int j = 0; j < SN; j++) begin
      gx = (j < SW - 1) ? 10'(orig[j+1] - orig[j]) : 10'($urandom);
      gy = (j + SW < SN) ? 10'(orig[j+SW] - orig[j]) : 10'($urandom);
      grad_mem[j] = {gx, gy};
    end
    exp_q.delete();
    for (int k = 0; k < SN; k++) exp_q.push_back(8'(orig[k]));
    exp_errs = 0;
  endtask

  // Driver: start a frame on the small instance and capture every cycle until done.
  task automatic run_small(input logic [7:0] sd, input int g1, input int g2);
    cap_n = 0; done_cyc = -1; rd_n = 0;
    @(posedge clk); #1; s_start = 1'b1; s_seed = sd;
    @(posedge clk); #1; s_start = 1'b0; s_seed = ~sd;
    busy0 = s_busy;
    for (int cyc = 0; cyc < SN + 8; cyc++) begin
      s_start = (cyc == g1 || cyc == g2);
      if (s_img_wr) begin
        if (cap_n < SN) begin
          cap_data[cap_n] = s_img_do; cap_addr[cap_n] = s_img_addr; cap_cyc[cap_n] = cyc;
        end
        cap_n++;
      end
      if (s_grad_rd) rd_n++;
      if (s_done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    s_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({s_busy, s_done, s_err, s_grad_rd, s_img_wr} !== 5'b0 || s_err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_small_ctl got %b/%h want 0", {s_busy, s_done, s_err, s_grad_rd, s_img_wr}, s_err_cnt); end
    checks++; if (s_grad_addr !== 8'h0 || s_img_addr !== 8'h0 || s_img_do !== 8'h0 || s_dbg !== IDLE) begin
      errors++; $display("FAIL reset_small_data got %h %h %h %0d want 0", s_grad_addr, s_img_addr, s_img_do, s_dbg); end
    checks++; if ({b_busy, b_done, b_err, b_grad_rd, b_img_wr} !== 5'b0 || b_img_addr !== 16'h0 || b_img_do !== 8'h0) begin
      errors++; $display("FAIL reset_big got %b %h %h want 0", {b_busy, b_done, b_err, b_grad_rd, b_img_wr}, b_img_addr, b_img_do); end
  endtask

  task automatic test_full_frame();
    int n = 0, bad = 0, dcyc = -1;
    @(posedge clk); #1; b_start = 1'b1; b_seed = 8'd100;
    @(posedge clk); #1; b_start = 1'b0; b_seed = 8'd7;
    for (int cyc = 0; cyc < BN + 16; cyc++) begin
      if (b_img_wr) begin
        if (b_img_addr !== 16'(n) || b_img_do !== 8'd100 || cyc != n) bad++;
        n++;
      end
      if (b_done) begin dcyc = cyc; break; end
      @(posedge clk); #1;
    end
    checks++; if (n != BN) begin errors++; $display("FAIL full_writes got %0d want %0d", n, BN); end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_pixels got %0d bad want 0", bad); end
    checks++; if (dcyc != BN) begin errors++; $display("FAIL full_done_cycle got %0d want %0d", dcyc, BN); end
    checks++; if (b_err !== 1'b0 || b_err_cnt !== 16'h0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL full_err got %b %0d busy %b want 0 0 0", b_err, b_err_cnt, b_busy); end
  endtask

  task automatic test_patterns();
    logic [7:0] sd;
    logic [19:0] word;
    int bad;
    for (int pi = 0; pi < 3; pi++) begin
      case (pi)
        0: begin sd = 8'd0;   word = {10'd1, 10'd0}; end
        1: begin sd = 8'd200; word = {10'd0, 10'h3F6}; end
        default: begin sd = 8'd250; word = {10'd10, 10'd0}; end
      endcase
      for (int j = 0; j < 256; j++) grad_mem[j] = word;
      build_expected(int'(sd));
      if (pi > 0) begin
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL done_hold p%0d got %b want 1", pi, s_done); end
      end
      run_small(sd, -1, -1);
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_first p%0d got %b want 1", pi, busy0); end
      checks++; if (cap_n != SN) begin errors++; $display("FAIL writes p%0d got %0d want %0d", pi, cap_n, SN); end
      bad = 0;
      for (int i = 0; i < SN; i++) begin
        checks++; if (cap_data[i] !== exp_q[i] || cap_addr[i] !== 8'(i) || cap_cyc[i] != i) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL pix p%0d i%0d got %0d@%0d c%0d want %0d", pi, i, cap_data[i], cap_addr[i], cap_cyc[i], exp_q[i]);
        end
      end
      checks++; if (done_cyc != SN) begin errors++; $display("FAIL done_cycle p%0d got %0d want %0d", pi, done_cyc, SN); end
      checks++; if (rd_n != SN - 1) begin errors++; $display("FAIL reads p%0d got %0d want %0d", pi, rd_n, SN - 1); end
`ifdef IG_RECON_CLAMP_EN
      checks++; if (s_err !== (exp_errs > 0) || s_err_cnt !== 16'(exp_errs)) begin
        errors++; $display("FAIL err p%0d got %b %0d want %b %0d", pi, s_err, s_err_cnt, exp_errs > 0, exp_errs); end
`else
      checks++; if (s_err !== 1'b0 || s_err_cnt !== 16'h0) begin
        errors++; $display("FAIL err p%0d got %b %0d want 0 0", pi, s_err, s_err_cnt); end
`endif
      case (pi)
        0: begin checks++; if (cap_data[63] !== 8'd7) begin errors++; $display("FAIL ramp_last got %0d want 7", cap_data[63]); end end
        1: begin checks++; if (cap_data[56] !== 8'd130) begin errors++; $display("FAIL row7 got %0d want 130", cap_data[56]); end end
        default: begin
`ifdef IG_RECON_CLAMP_EN
          checks++; if (cap_data[1] !== 8'd255 || cap_data[57] !== 8'd255) begin
            errors++; $display("FAIL clamp got %0d %0d want 255", cap_data[1], cap_data[57]); end
`else
          checks++; if (cap_data[1] !== 8'd4 || cap_data[57] !== 8'd4) begin
            errors++; $display("FAIL wrap got %0d %0d want 4", cap_data[1], cap_data[57]); end
`endif
        end
      endcase
    end
  endtask

  // Random images; the second frame also pulses start mid-frame.
  task automatic test_random();
    int bad;
    for (int it = 0; it < 3; it++) begin
      make_random_image();
      if (it == 0) run_small(8'(orig[0]), -1, -1);
      else run_small(8'(orig[0]), int'($urandom_range(1, 30)), int'($urandom_range(31, SN - 1)));
      bad = 0;
      checks++; if (cap_n != SN) begin errors++; $display("FAIL rnd_writes it%0d got %0d want %0d", it, cap_n, SN); end
      for (int i = 0; i < SN; i++) begin
        checks++; if (cap_data[i] !== exp_q[i] || cap_addr[i] !== 8'(i) || cap_cyc[i] != i) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL rnd_pix it%0d i%0d got %0d@%0d want %0d", it, i, cap_data[i], cap_addr[i], exp_q[i]);
        end
      end
      checks++; if (done_cyc != SN || s_err !== 1'b0 || s_err_cnt !== 16'h0) begin
        errors++; $display("FAIL rnd_end it%0d got done@%0d err %b %0d want done@%0d 0 0", it, done_cyc, s_err, s_err_cnt, SN); end
    end
  endtask

  task automatic test_reset_mid();
    int hit = 0, bad = 0;
    make_random_image();
    @(posedge clk); #1; s_start = 1'b1; s_seed = 8'(orig[0]);
    @(posedge clk); #1; s_start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (s_img_wr && s_img_addr == 8'd20) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++; if (hit != 1) begin errors++; $display("FAIL mid_reach got %0d want 1", hit); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({s_img_wr, s_grad_rd, s_busy, s_done} !== 4'b0 || s_dbg !== IDLE) begin
      errors++; $display("FAIL mid_reset got %b st %0d want 0000 st 0", {s_img_wr, s_grad_rd, s_busy, s_done}, s_dbg); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if ({s_img_wr, s_grad_rd, s_busy, s_done} !== 4'b0) begin
      errors++; $display("FAIL mid_idle got %b want 0000", {s_img_wr, s_grad_rd, s_busy, s_done}); end
    run_small(8'(orig[0]), -1, -1);
    for (int i = 0; i < SN; i++) if (cap_data[i] !== exp_q[i] || cap_addr[i] !== 8'(i)) bad++;
    checks++; if (bad != 0 || cap_n != SN || done_cyc != SN) begin
      errors++; $display("FAIL mid_rerun got bad %0d writes %0d done@%0d want 0 %0d %0d", bad, cap_n, done_cyc, SN, SN); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_frame();
    test_patterns();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
